// File: rtl/dbg_regfile_port.sv
// rtl/dbg_regfile_port.sv - debug initiator sharing the integer register file port with the core
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   halted            core halted and pipeline drained
//   core_*            core pipeline register file requests (read port 1, write port)
//   rf_*              muxed register file port; rf_rdata1 returns combinationally
//   req_*             debug command: valid/ready, write flag, register index, write data
//   resp_*            debug response: valid/ready, read data, error flag
module dbg_regfile_port #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     halted,
    input  logic                     core_rden1,
    input  logic [$clog2(NREGS)-1:0] core_raddr1,
    input  logic                     core_wren,
    input  logic [$clog2(NREGS)-1:0] core_waddr,
    input  logic [XLEN-1:0]          core_wdata,
    output logic                     rf_rden1,
    output logic [$clog2(NREGS)-1:0] rf_raddr1,
    output logic                     rf_wren,
    output logic [$clog2(NREGS)-1:0] rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic [XLEN-1:0]          rf_rdata1,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [$clog2(NREGS)-1:0] req_addr,
    input  logic [XLEN-1:0]          req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [XLEN-1:0]          resp_rdata,
    output logic                     resp_err
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [XLEN-1:0] cmd_wdata;
    logic            blk_drive;

    assign req_ready = (state == IDLE);

    // The port is borrowed only while halted. Gating with rst keeps a reset
    // asserted during ACCESS from letting the pending write reach the file.
    assign blk_drive = (state == ACCESS) && halted && rst;

    always_comb begin
        rf_rden1  = core_rden1;
        rf_raddr1 = core_raddr1;
        rf_wren   = core_wren;
        rf_waddr  = core_waddr;
        rf_wdata  = core_wdata;
        if (blk_drive) begin
            // Core requests are dropped in this cycle; the halted core has none.
            rf_rden1  = !cmd_write;
            rf_raddr1 = cmd_write ? '0 : cmd_addr;
            rf_wren   = cmd_write && (cmd_addr != '0);
            rf_waddr  = cmd_write ? cmd_addr : '0;
            rf_wdata  = cmd_write ? cmd_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cmd_write <= req_write;
                        cmd_addr  <= req_addr;
                        cmd_wdata <= req_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                    if (!halted) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else if (!cmd_write) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= rf_rdata1;
                    end else begin
                        // Writes, including the silently dropped x0 write, return zero data.
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_regfile_port.sv
// tb/tb_dbg_regfile_port.sv - randomized self-checking bench for dbg_regfile_port
module tb_dbg_regfile_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic        core_rden1;
    logic [4:0]  core_raddr1;
    logic        core_wren;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        rf_rden1;
    logic [4:0]  rf_raddr1;
    logic        rf_wren;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata1;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    // Raw register file: no x0 special case, so any stray x0 write is visible on readback.
    logic [31:0] rf_mem [32];
    // Reference architectural state as the debugger should see it.
    logic [31:0] ref_regs [32];

    always #5 clk = ~clk;

    assign rf_rdata1 = rf_mem[rf_raddr1];

    always @(posedge clk) begin
        if (rf_wren) rf_mem[rf_waddr] <= rf_wdata;
    end

    dbg_regfile_port #(.NREGS(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .halted(halted),
        .core_rden1(core_rden1), .core_raddr1(core_raddr1),
        .core_wren(core_wren), .core_waddr(core_waddr), .core_wdata(core_wdata),
        .rf_rden1(rf_rden1), .rf_raddr1(rf_raddr1),
        .rf_wren(rf_wren), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_rdata1(rf_rdata1),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    // Issue one command from IDLE, count port activity, and complete the response.
    task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nwr, output int nrd);
        int waits;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nwr = 0; nrd = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rf_wren) nwr++;
            if (rf_rden1) nrd++;
            if (resp_valid) break;
        end
        total++;
        if (resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout resp_valid=%0b required=1", resp_valid);
        end
        rdata = resp_rdata;
        err   = resp_err;
        waits = $urandom_range(0, 2);
        repeat (waits) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%0b exp=0", resp_err); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_passthrough;
        halted = 1'b0;
        core_wren = 1'b1; core_waddr = 5'd5; core_wdata = 32'hA5A5A5A5;
        core_rden1 = 1'b1; core_raddr1 = 5'd3;
        @(negedge clk);
        total++;
        if ({rf_wren, rf_waddr, rf_wdata, rf_rden1, rf_raddr1} !== {1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd3}) begin
            bad++;
            $display("FAIL passthrough got wren=%0b waddr=%0d wdata=%h rden=%0b raddr=%0d exp 1/5/a5a5a5a5/1/3",
                     rf_wren, rf_waddr, rf_wdata, rf_rden1, rf_raddr1);
        end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL passthrough_req_ready got=%0b exp=1", req_ready); end
        @(posedge clk); #1;
        ref_regs[5] = 32'hA5A5A5A5;
        core_wren = 1'b0; core_waddr = '0; core_wdata = '0; core_rden1 = 1'b0; core_raddr1 = '0;
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic er; int lat, nwr, nrd;
        halted = 1'b1;
        send(1'b1, 5'd7, 32'h12345678, rd, er, lat, nwr, nrd);
        ref_regs[7] = 32'h12345678;
        total++; if (lat != 2) begin bad++; $display("FAIL wr7_latency got=%0d exp=2", lat); end
        total++; if (nwr != 1 || nrd != 0) begin bad++; $display("FAIL wr7_port got wren_cycles=%0d rden_cycles=%0d exp 1/0", nwr, nrd); end
        total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL wr7_resp got err=%0b rdata=%h exp 0/0", er, rd); end
        send(1'b0, 5'd7, 32'h0, rd, er, lat, nwr, nrd);
        total++; if (rd !== ref_regs[7] || er !== 1'b0) begin bad++; $display("FAIL rd7_resp got err=%0b rdata=%h exp 0/%h", er, rd, ref_regs[7]); end
        total++; if (nrd != 1 || nwr != 0) begin bad++; $display("FAIL rd7_port got rden_cycles=%0d wren_cycles=%0d exp 1/0", nrd, nwr); end
    endtask

    task automatic test_x0;
        logic [31:0] rd; logic er; int lat, nwr, nrd;
        halted = 1'b1;
        send(1'b1, 5'd0, 32'hFFFFFFFF, rd, er, lat, nwr, nrd);
        total++; if (nwr != 0) begin bad++; $display("FAIL x0_write_port got wren_cycles=%0d exp=0", nwr); end
        total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL x0_write_resp got err=%0b rdata=%h exp 0/0", er, rd); end
        send(1'b0, 5'd0, 32'h0, rd, er, lat, nwr, nrd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL x0_read got=%h exp=0", rd); end
    endtask

    task automatic test_not_halted;
        logic [31:0] rd; logic er; int lat, nwr, nrd;
        halted = 1'b0;
        send(1'b0, 5'd3, 32'h0, rd, er, lat, nwr, nrd);
        total++; if (nrd != 0) begin bad++; $display("FAIL nohalt_port got rden_cycles=%0d exp=0", nrd); end
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL nohalt_resp got err=%0b rdata=%h exp 1/0", er, rd); end
        total++; if (lat != 2) begin bad++; $display("FAIL nohalt_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [31:0] rd; logic er; int lat, nwr, nrd;
        halted = 1'b1;
        req_write = 1'b0; req_addr = 5'd5; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        // A second command is presented immediately and held through the backpressure.
        req_write = 1'b1; req_addr = 5'd10; req_wdata = 32'h0BADF00D;
        @(negedge clk);
        total++; if (rf_rden1 !== 1'b1 || rf_wren !== 1'b0) begin bad++; $display("FAIL bp_access got rden=%0b wren=%0b exp 1/0", rf_rden1, rf_wren); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== ref_regs[5] || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got valid=%0b rdata=%h err=%0b req_ready=%0b exp 1/%h/0/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, ref_regs[5]);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got req_ready=%0b resp_valid=%0b exp 1/0", req_ready, resp_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rf_wren !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL bp_second_write got wren=%0b waddr=%0d wdata=%h exp 1/10/0badf00d", rf_wren, rf_waddr, rf_wdata);
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        ref_regs[10] = 32'h0BADF00D;
        send(1'b0, 5'd10, 32'h0, rd, er, lat, nwr, nrd);
        total++; if (rd !== ref_regs[10]) begin bad++; $display("FAIL bp_readback got=%h exp=%h", rd, ref_regs[10]); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat, nwr, nrd;
        halted = 1'b1;
        req_write = 1'b1; req_addr = 5'd9; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++; if (rf_wren !== 1'b0) begin bad++; $display("FAIL rstmid_wren got=%0b exp=0", rf_wren); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_idle cycle=%0d got resp_valid=%0b req_ready=%0b exp 0/1", i, resp_valid, req_ready);
            end
        end
        @(posedge clk); #1;
        send(1'b0, 5'd9, 32'h0, rd, er, lat, nwr, nrd);
        total++; if (rd !== ref_regs[9]) begin bad++; $display("FAIL rstmid_readback got=%h exp=%h", rd, ref_regs[9]); end
    endtask

    task automatic test_random;
        logic [31:0] rd, d, exp_rd; logic er, w, exp_er; logic [4:0] a;
        int lat, nwr, nrd, exp_wr, exp_rdn;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            halted = ($urandom_range(0, 3) != 0);
            if (!halted) begin
                exp_er = 1'b1; exp_rd = 32'h0; exp_wr = 0; exp_rdn = 0;
            end else if (w) begin
                exp_er = 1'b0; exp_rd = 32'h0; exp_rdn = 0;
                exp_wr = (a != 0) ? 1 : 0;
                if (a != 0) ref_regs[a] = d;
            end else begin
                exp_er = 1'b0; exp_rd = ref_regs[a]; exp_wr = 0; exp_rdn = 1;
            end
            send(w, a, d, rd, er, lat, nwr, nrd);
            total++;
            if (rd !== exp_rd || er !== exp_er || lat != 2 || nwr != exp_wr || nrd != exp_rdn) begin
                bad++;
                $display("FAIL random i=%0d w=%0b a=%0d halted=%0b got rdata=%h err=%0b lat=%0d wr=%0d rd=%0d exp %h/%0b/2/%0d/%0d",
                         i, w, a, halted, rd, er, lat, nwr, nrd, exp_rd, exp_er, exp_wr, exp_rdn);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i]   = 32'h0;
            ref_regs[i] = 32'h0;
        end
        rst = 1'b0; halted = 1'b0;
        core_rden1 = 1'b0; core_raddr1 = '0; core_wren = 1'b0; core_waddr = '0; core_wdata = '0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        test_reset;
        test_passthrough;
        test_write_read;
        test_x0;
        test_not_halted;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
